// File: rtl/prewish_pkg.sv
// Shared definitions for the prewish mask-write arbiter.
//   - State encoding of the arbiter FSM (IDLE / ISSUE / GAP).
//   - Default mask/data width.
//   - ptr_w(): width of the round-robin pointer / winner index for n requesters.
package prewish_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b11;

  localparam int DATA_W_DEF = 8;

  // A single requester would give $clog2 of 0; keep at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prewish_rr_picker.sv
// Combinational round-robin picker.
// Finds the first asserted request bit searching upward from i_ptr,
// wrapping modulo NUM_REQ.
// Ports:
//   i_req    : request vector, bit i = requester i
//   i_ptr    : index of the highest-priority requester this round
//   o_onehot : one-hot winner (all zero when nothing is requested)
//   o_idx    : winner index (0 when nothing is requested)
//   o_valid  : at least one request is asserted
module prewish_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    // Walk from the farthest position back to the pointer so that the
    // closest asserted request (smallest offset) is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int w_pos;
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (i_req[w_pos]) begin
        o_onehot = ONE << w_pos;
        o_idx    = PTR_W'(w_pos);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prewish_mask_arbiter.sv
// Round-robin arbiter sharing the blinky mask-write port (one-cycle STB_O
// plus DAT_O mask) between NUM_REQ requesters. A granted requester gets a
// one-cycle ACK, the mask is strobed on the following cycle, and GAP_CYCLES
// extra idle cycles follow each strobe.
// Ports:
//   CLK_I, RST_I : clock, synchronous active-high reset
//   REQ_STB_I    : per-requester request levels
//   REQ_DAT_I    : requester i data in [i*DATA_W +: DATA_W]
//   REQ_ACK_O    : one-hot one-cycle accept pulse
//   STB_O        : one-cycle write strobe to the blinky
//   DAT_O        : mask, held from the ACK cycle until the next grant
//   BUSY_O       : high whenever the arbiter is not IDLE
//   o_alive      : only with PREWISH_ARB_ALIVE_EN defined; inverted toggle
//                  that flips on every grant (debug LED)
module prewish_mask_arbiter
  import prewish_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic [NUM_REQ-1:0]        REQ_STB_I,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DAT_I,
  output logic [NUM_REQ-1:0]        REQ_ACK_O,
  output logic                      STB_O,
  output logic [DATA_W-1:0]         DAT_O,
`ifdef PREWISH_ARB_ALIVE_EN
  output logic                      BUSY_O,
  output logic                      o_alive
`else
  output logic                      BUSY_O
`endif
);

  localparam int               PTR_W    = ptr_w(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]       GAP_LD   = 8'(GAP_CYCLES);

  logic [1:0]         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [7:0]         r_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_stb;
  logic [DATA_W-1:0]  r_dat;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_onehot;
  logic [PTR_W-1:0]   w_idx;
  logic               w_valid;
  logic [DATA_W-1:0]  w_dat;

  prewish_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req    (REQ_STB_I),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  assign w_dat = REQ_DAT_I[w_idx*DATA_W +: DATA_W];

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_stb   <= 1'b0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_stb <= 1'b0;
          r_ack <= '0;
          if (w_valid) begin
            r_ack   <= w_onehot;
            r_dat   <= w_dat;
            r_ptr   <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_ack <= '0;
          r_stb <= 1'b1;
          if (GAP_CYCLES == 0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= GAP_LD;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Requests are not looked at here; they stay pending as levels.
          r_stb <= 1'b0;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 8'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_stb   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign REQ_ACK_O = r_ack;
  assign STB_O     = r_stb;
  assign DAT_O     = r_dat;
  assign BUSY_O    = r_busy;

`ifdef PREWISH_ARB_ALIVE_EN
  logic r_tgl;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_tgl <= 1'b0;
    end else if (r_state == ST_IDLE && w_valid) begin
      r_tgl <= ~r_tgl;
    end
  end

  assign o_alive = ~r_tgl;
`endif

endmodule
